// File: rtl/cla_nbit_reg_if.sv
// Purpose: bundles the adder operand and result signals of cla_nbit_reg.
// Signals:
//   A, B  : N-bit operands (unsigned or two's-complement bit patterns)
//   Cin   : carry into bit 0
//   Sum   : registered N-bit sum
//   Cout  : registered carry out of bit N-1
// Modports:
//   master : drives the operands and observes the result (test side)
//   slave  : the adder itself
interface cla_nbit_reg_if #(
  parameter int N = 16
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] Sum;
  logic         Cout;

  modport master (output A, output B, output Cin, input Sum, input Cout);
  modport slave  (input A, input B, input Cin, output Sum, output Cout);
endinterface

// File: rtl/cla_nbit_reg.sv
// Purpose: N-bit two-level carry-lookahead adder with registered outputs.
//   Final adder of the radix-4 Booth MAC partial-product sum.
//   {Cout,Sum} = A + B + Cin, one cycle of latency, one add per cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears Sum and Cout at once
//   bus : cla_nbit_reg_if slave modport (A, B, Cin in; Sum, Cout out)
// Parameter N: operand width, a multiple of 4 and at least 4.
module cla_nbit_reg #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  cla_nbit_reg_if.slave  bus
);

  localparam int NG = N / 4;        // 4-bit groups
  localparam int NB = (NG + 3) / 4; // blocks of 4 groups at the second level

  // Sum-of-products lookahead carry after the first n positions of a 4-wide
  // slice: c_n = g[n-1] | p[n-1]g[n-2] | ... | p[n-1]..p[0]cin.
  // Used for both the in-group bit carries and the group carries.
  function automatic logic la_carry(input logic [3:0] g, input logic [3:0] p,
                                    input logic cin, input int n);
    logic c;
    logic prod;
    c = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j < n) begin
        prod = g[j];
        for (int m = 0; m < 4; m++) begin
          if (m > j && m < n) prod = prod & p[m];
        end
        c = c | prod;
      end
    end
    prod = cin;
    for (int m = 0; m < 4; m++) begin
      if (m < n) prod = prod & p[m];
    end
    return c | prod;
  endfunction

  logic [N-1:0]    w_p;
  logic [N-1:0]    w_g;
  logic [N-1:0]    w_c;     // carry into each bit
  logic [4*NB-1:0] w_pg;    // group propagate, zero-padded to whole blocks
  logic [4*NB-1:0] w_gg;    // group generate, zero-padded to whole blocks
  logic [NG:0]     w_cgrp;  // carry into each group; w_cgrp[NG] is carry out
  logic [N-1:0]    w_sum;
  logic            w_cout;

  logic [N-1:0]    r_sum;
  logic            r_cout;

  always_comb begin
    w_p    = bus.A ^ bus.B;
    w_g    = bus.A & bus.B;
    w_pg   = '0;
    w_gg   = '0;
    w_cgrp = '0;
    w_c    = '0;

    for (int k = 0; k < NG; k++) begin
      w_pg[k] = &w_p[4*k +: 4];
      w_gg[k] = la_carry(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0, 4);
    end

    // Group carries are expanded within each block of 4 groups from the
    // block's carry-in; blocks chain through their last group carry.
    w_cgrp[0] = bus.Cin;
    for (int k = 1; k <= NG; k++) begin
      w_cgrp[k] = la_carry(w_gg[((k-1)/4)*4 +: 4], w_pg[((k-1)/4)*4 +: 4],
                           w_cgrp[((k-1)/4)*4], k - ((k-1)/4)*4);
    end

    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        w_c[4*k+i] = la_carry(w_g[4*k +: 4], w_p[4*k +: 4], w_cgrp[k], i);
      end
    end

    w_sum  = w_p ^ w_c;
    w_cout = w_cgrp[NG];
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
    end
  end

  assign bus.Sum  = r_sum;
  assign bus.Cout = r_cout;

endmodule

// File: tb/tb_cla_nbit_reg.sv
module tb_cla_nbit_reg;

  logic clk;
  logic rst;
  int   nchk;
  int   nerr;

  cla_nbit_reg_if #(.N(16)) bus ();

  cla_nbit_reg #(.N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [15:0] es, input logic ec);
    nchk++;
    if (bus.Sum !== es || bus.Cout !== ec) begin
      nerr++;
      $display("FAIL %s: got Sum=%h Cout=%b, want Sum=%h Cout=%b",
               nm, bus.Sum, bus.Cout, es, ec);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.A   = a;
    bus.B   = b;
    bus.Cin = c;
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] pa, pb;
    logic        pc;

    nchk = 0;
    nerr = 0;

    vecs[0]  = '{16'd10,   16'd20,   1'b0, 16'd30,   1'b0};
    vecs[1]  = '{16'd1234, 16'd4321, 1'b0, 16'd5555, 1'b0};
    vecs[2]  = '{16'hFFF1, 16'd5,    1'b1, 16'hFFF7, 1'b0};
    vecs[3]  = '{16'd30,   16'hFFF6, 1'b0, 16'd20,   1'b1};
    vecs[4]  = '{16'hFFE7, 16'hFFF1, 1'b1, 16'hFFD9, 1'b1};
    vecs[5]  = '{16'd5,    16'hFFF8, 1'b1, 16'hFFFE, 1'b0};
    vecs[6]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[7]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1};
    vecs[8]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[10] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};

    // Reset with nonzero inputs: outputs held at zero across clock edges.
    rst = 1'b1;
    drive(16'h1234, 16'h4321, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", 16'h0000, 1'b0);
    rst = 1'b0;
    #1 chk("reset_release_no_edge", 16'h0000, 1'b0);

    // Directed table, one vector per cycle, checked one cycle later.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout);
    end

    // Mid-stream reset: output clears immediately, without a clock edge.
    @(negedge clk);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    #2 chk("pre_reset_value", 16'hFFFF, 1'b1);
    rst = 1'b1;
    #1 chk("async_reset_clear", 16'h0000, 1'b0);
    @(posedge clk);
    #1 chk("reset_over_edge", 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(16'd100, 16'd23, 1'b1);
    #1 chk("deassert_no_edge", 16'h0000, 1'b0);
    @(posedge clk);
    #1 chk("first_after_reset", 16'd124, 1'b0);

    // Back-to-back random vectors, result compared one cycle later.
    @(negedge clk);
    pa = 16'($urandom);
    pb = 16'($urandom);
    pc = 1'($urandom);
    drive(pa, pb, pc);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      full = {1'b0, pa} + {1'b0, pb} + {16'h0000, pc};
      chk($sformatf("rand%0d", i), full[15:0], full[16]);
      pa = 16'($urandom);
      pb = 16'($urandom);
      pc = 1'($urandom);
      drive(pa, pb, pc);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
